// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue behind the UART receiver: captures bytes on the done tick,
// presents them through a show-ahead valid/ready port, and flags bytes dropped while full.
module uart_rx_fifo #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DBIT-1:0] wr_data,
    input  logic            wr_tick,
    output logic [DBIT-1:0] rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [AW:0]     count,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    input  logic            ovf_clr
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DBIT-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, drop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a tick while full is still accepted then.
    assign pop  = rd_valid & rd_ready;
    assign push = wr_tick & (~full | pop);
    assign drop = wr_tick & full & ~pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
